// File: rtl/ascii_hex_parser.sv
`default_nettype none
// ============================================================================
// Module      : ascii_hex_parser
// Description : Turns a stream of ASCII characters from the UART or keyboard
//               front end into a binary value for the debug console.
//               Hex digits accumulate MSB-first. A terminator (CR, LF or
//               space) commits the accumulated value. BS deletes the last
//               digit and ESC abandons the entry. A bad character or a
//               digit overflow discards the whole entry at its terminator
//               and raises a one-cycle error pulse.
//               The live accumulator is exported so the display formatter
//               can echo it while the user types.
// Ports       : clk          system clock, rising edge
//               rst_n        synchronous reset, active-low
//               char_valid   char_data is valid this cycle
//               char_data    ASCII character
//               char_ready   parser can accept (low only in the commit cycle)
//               acc          live partial value, right-aligned
//               digit_cnt    number of digits held in acc
//               value        last committed value, held until the next commit
//               value_valid  one-cycle pulse: value was updated
//               err          one-cycle pulse: an erroneous entry was discarded
// Revision    : 1.0 - initial release
// ============================================================================
module ascii_hex_parser #(
    parameter int MAX_DIGITS = 8,   // 1..15
    parameter int OUT_W      = 32   // must equal 4*MAX_DIGITS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             char_valid,
    input  logic [7:0]       char_data,
    output logic             char_ready,
    output logic [OUT_W-1:0] acc,
    output logic [3:0]       digit_cnt,
    output logic [OUT_W-1:0] value,
    output logic             value_valid,
    output logic             err
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ACCUM = 2'd1;
    localparam logic [1:0] c_BAD   = 2'd2;
    localparam logic [1:0] c_EMIT  = 2'd3;

    localparam logic [3:0] c_MAX_CNT = MAX_DIGITS[3:0];

    logic [1:0]       r_state, w_state_nxt;
    logic [OUT_W-1:0] r_acc, w_acc_nxt;
    logic [3:0]       r_cnt, w_cnt_nxt;
    logic [OUT_W-1:0] r_value, w_value_nxt;
    logic             r_value_valid, w_value_valid_nxt;
    logic             r_err, w_err_nxt;

    logic             w_xfer;
    logic             w_is_hex, w_is_bs, w_is_esc, w_is_term;
    logic [3:0]       w_nibble;

    // ------------------------------------------------------------------
    // Character classification
    // ------------------------------------------------------------------
    always_comb begin
        w_is_hex = 1'b0;
        w_nibble = 4'd0;
        if (char_data >= 8'h30 && char_data <= 8'h39) begin
            w_is_hex = 1'b1;
            w_nibble = char_data[3:0];
        end else if ((char_data >= 8'h41 && char_data <= 8'h46) ||
                     (char_data >= 8'h61 && char_data <= 8'h66)) begin
            // 'A'/'a' have low nibble 1, so adding 9 maps them to 10..15
            w_is_hex = 1'b1;
            w_nibble = char_data[3:0] + 4'd9;
        end
    end

    assign w_is_bs   = (char_data == 8'h08);
    assign w_is_esc  = (char_data == 8'h1B);
    assign w_is_term = (char_data == 8'h0D) || (char_data == 8'h0A) ||
                       (char_data == 8'h20);

    assign char_ready = (r_state != c_EMIT);
    assign w_xfer     = char_valid & char_ready;

    // ------------------------------------------------------------------
    // Next-state and datapath
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt       = r_state;
        w_acc_nxt         = r_acc;
        w_cnt_nxt         = r_cnt;
        w_value_nxt       = r_value;
        w_value_valid_nxt = 1'b0;
        w_err_nxt         = 1'b0;

        case (r_state)
            c_IDLE, c_ACCUM: begin
                if (w_xfer) begin
                    if (w_is_hex) begin
                        if (r_cnt < c_MAX_CNT) begin
                            w_acc_nxt   = (r_acc << 4) | OUT_W'(w_nibble);
                            w_cnt_nxt   = r_cnt + 4'd1;
                            w_state_nxt = c_ACCUM;
                        end else begin
                            // Overflow: keep what is shown, swallow until a terminator
                            w_state_nxt = c_BAD;
                        end
                    end else if (w_is_bs) begin
                        if (r_cnt != 4'd0) begin
                            w_acc_nxt   = r_acc >> 4;
                            w_cnt_nxt   = r_cnt - 4'd1;
                            w_state_nxt = (r_cnt == 4'd1) ? c_IDLE : c_ACCUM;
                        end
                    end else if (w_is_term) begin
                        // An empty entry never commits, so CR LF or a run of
                        // spaces produces at most one value
                        if (r_cnt != 4'd0) begin
                            w_value_nxt       = r_acc;
                            w_acc_nxt         = '0;
                            w_cnt_nxt         = 4'd0;
                            w_value_valid_nxt = 1'b1;
                            w_state_nxt       = c_EMIT;
                        end
                    end else if (w_is_esc) begin
                        w_acc_nxt   = '0;
                        w_cnt_nxt   = 4'd0;
                        w_state_nxt = c_IDLE;
                    end else begin
                        w_state_nxt = c_BAD;
                    end
                end
            end

            c_BAD: begin
                if (w_xfer) begin
                    if (w_is_term) begin
                        w_err_nxt   = 1'b1;
                        w_acc_nxt   = '0;
                        w_cnt_nxt   = 4'd0;
                        w_state_nxt = c_IDLE;
                    end else if (w_is_esc) begin
                        w_acc_nxt   = '0;
                        w_cnt_nxt   = 4'd0;
                        w_state_nxt = c_IDLE;
                    end
                end
            end

            c_EMIT: begin
                w_state_nxt = c_IDLE;
            end

            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= c_IDLE;
            r_acc         <= '0;
            r_cnt         <= 4'd0;
            r_value       <= '0;
            r_value_valid <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_acc         <= w_acc_nxt;
            r_cnt         <= w_cnt_nxt;
            r_value       <= w_value_nxt;
            r_value_valid <= w_value_valid_nxt;
            r_err         <= w_err_nxt;
        end
    end

    assign acc         = r_acc;
    assign digit_cnt   = r_cnt;
    assign value       = r_value;
    assign value_valid = r_value_valid;
    assign err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ascii_hex_parser.sv
`default_nettype none
// ============================================================================
// Module      : tb_ascii_hex_parser
// Description : Self-checking bench for ascii_hex_parser. A table of
//               character strings with their expected commit/error
//               outcomes is applied twice, once back-to-back and once with
//               idle gaps. Hand-written sequences cover commit and error
//               latency, back-pressure in the commit cycle, and reset in
//               the middle of an entry.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ascii_hex_parser;

    localparam int c_MAX_DIGITS = 8;
    localparam int c_OUT_W      = 32;

    logic        clk;
    logic        rst_n;
    logic        char_valid;
    logic [7:0]  char_data;
    logic        char_ready;
    logic [31:0] acc;
    logic [3:0]  digit_cnt;
    logic [31:0] value;
    logic        value_valid;
    logic        err;

    ascii_hex_parser #(
        .MAX_DIGITS (c_MAX_DIGITS),
        .OUT_W      (c_OUT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .char_valid  (char_valid),
        .char_data   (char_data),
        .char_ready  (char_ready),
        .acc         (acc),
        .digit_cnt   (digit_cnt),
        .value       (value),
        .value_valid (value_valid),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Pulse monitor, sampled mid-cycle
    int vv_pulses   = 0;
    int err_pulses  = 0;
    int both_pulses = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (value_valid) vv_pulses++;
            if (err) err_pulses++;
            if (value_valid && err) both_pulses++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; returns 1 unit after
    // the edge at which the character was accepted.
    task automatic send(input logic [7:0] c, input int gap);
        int budget;
        budget = 20;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        char_valid = 1'b1;
        char_data  = c;
        while (!char_ready && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        if (!char_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: char_ready stayed %b, expected 1", char_ready);
        end else begin
            @(posedge clk);
            #1;
        end
        char_valid = 1'b0;
    endtask

    task automatic send_str(input string s, input int max_gap);
        for (int i = 0; i < s.len(); i++)
            send(s[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    typedef struct {
        string       s;
        int          n_vv;
        logic [31:0] val;
        int          n_err;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int vv0, err0;

        // Octal escapes: \010 BS, \012 LF, \015 CR, \033 ESC
        vecs[0]  = '{s: "1A2b\015",        n_vv: 1, val: 32'h00001A2B, n_err: 0};
        vecs[1]  = '{s: "DEADBEEF \012",   n_vv: 1, val: 32'hDEADBEEF, n_err: 0};
        vecs[2]  = '{s: "\010123\0104\015", n_vv: 1, val: 32'h00000124, n_err: 0};
        vecs[3]  = '{s: "12G3\015",        n_vv: 0, val: 32'h00000124, n_err: 1};
        vecs[4]  = '{s: "123456789\015",   n_vv: 0, val: 32'h00000124, n_err: 1};
        vecs[5]  = '{s: "AB\033C\015",     n_vv: 1, val: 32'h0000000C, n_err: 0};
        vecs[6]  = '{s: "\010\015 \012",   n_vv: 0, val: 32'h0000000C, n_err: 0};
        vecs[7]  = '{s: "fedcba98\015",    n_vv: 1, val: 32'hFEDCBA98, n_err: 0};
        vecs[8]  = '{s: "Z\0335\015",      n_vv: 1, val: 32'h00000005, n_err: 0};
        vecs[9]  = '{s: "0\015",           n_vv: 1, val: 32'h00000000, n_err: 0};
        vecs[10] = '{s: "12345678\015",    n_vv: 1, val: 32'h12345678, n_err: 0};

        rst_n      = 1'b0;
        char_valid = 1'b0;
        char_data  = 8'h00;
        tick(3);
        check("reset_acc",   acc, 32'h0);
        check("reset_cnt",   {28'h0, digit_cnt}, 32'h0);
        check("reset_value", value, 32'h0);
        check("reset_vv",    {31'h0, value_valid}, 32'h0);
        check("reset_err",   {31'h0, err}, 32'h0);
        check("reset_ready", {31'h0, char_ready}, 32'h1);
        rst_n = 1'b1;
        tick(1);

        // Pass 0 back-to-back, pass 1 with random idle gaps
        for (int pass = 0; pass < 2; pass++) begin
            for (int v = 0; v < 11; v++) begin
                vv0  = vv_pulses;
                err0 = err_pulses;
                send_str(vecs[v].s, pass * 3);
                tick(3);
                check($sformatf("p%0d_v%0d_vv_pulses", pass, v), vv_pulses - vv0, vecs[v].n_vv);
                check($sformatf("p%0d_v%0d_err_pulses", pass, v), err_pulses - err0, vecs[v].n_err);
                check($sformatf("p%0d_v%0d_value", pass, v), value, vecs[v].val);
                check($sformatf("p%0d_v%0d_acc", pass, v), acc, 32'h0);
                check($sformatf("p%0d_v%0d_cnt", pass, v), {28'h0, digit_cnt}, 32'h0);
            end
        end

        // Commit latency and back-pressure during the commit cycle
        send("3", 0);
        check("lat_acc_before", acc, 32'h3);
        char_valid = 1'b1;
        char_data  = 8'h0D;
        tick(1);
        check("lat_vv",       {31'h0, value_valid}, 32'h1);
        check("lat_value",    value, 32'h3);
        check("lat_ready",    {31'h0, char_ready}, 32'h0);
        check("lat_acc",      acc, 32'h0);
        char_data = "7";
        tick(1);
        check("lat_vv_off",   {31'h0, value_valid}, 32'h0);
        check("lat_no_xfer",  acc, 32'h0);
        check("lat_ready_on", {31'h0, char_ready}, 32'h1);
        tick(1);
        char_valid = 1'b0;
        check("lat_next_acc", acc, 32'h7);
        check("lat_next_cnt", {28'h0, digit_cnt}, 32'h1);
        send(8'h1B, 0);
        check("esc_acc", acc, 32'h0);

        // Error pulse latency
        send("G", 0);
        char_valid = 1'b1;
        char_data  = 8'h0D;
        tick(1);
        char_valid = 1'b0;
        check("errlat_err",   {31'h0, err}, 32'h1);
        check("errlat_vv",    {31'h0, value_valid}, 32'h0);
        check("errlat_value", value, 32'h3);
        tick(1);
        check("errlat_off",   {31'h0, err}, 32'h0);

        // Backspace mid-entry, then reset drops the partial entry
        send_str("FFF", 0);
        check("fff_acc", acc, 32'h00000FFF);
        check("fff_cnt", {28'h0, digit_cnt}, 32'h3);
        send(8'h08, 0);
        check("bs_acc", acc, 32'h000000FF);
        check("bs_cnt", {28'h0, digit_cnt}, 32'h2);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        check("mrst_acc",   acc, 32'h0);
        check("mrst_cnt",   {28'h0, digit_cnt}, 32'h0);
        check("mrst_value", value, 32'h0);
        vv0 = vv_pulses;
        send_str("7\015", 2);
        tick(3);
        check("mrst_new_value", value, 32'h7);
        check("mrst_new_vv",    vv_pulses - vv0, 1);

        check("vv_err_exclusive", both_pulses, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
